// File: rtl/glycemic_alarm_monitor_if.sv
// Sample/acknowledge inputs and status outputs of the glycemic alarm monitor.
// The master side drives readings and acknowledges; the slave side is the monitor.
interface glycemic_alarm_monitor_if;
  logic       sampleValid;
  logic [3:0] glycemicIndex;
  logic       ackAlarm;
  logic       warning;
  logic       alarm;
  logic [3:0] peakIndex;
  logic [7:0] episodeCount;

  modport master (
    output sampleValid, glycemicIndex, ackAlarm,
    input  warning, alarm, peakIndex, episodeCount
  );

  modport slave (
    input  sampleValid, glycemicIndex, ackAlarm,
    output warning, alarm, peakIndex, episodeCount
  );
endinterface

// File: rtl/glycemic_alarm_monitor.sv
// Debounced alarm FSM over abnormality readings: raises an alarm after a run of
// abnormal samples, clears after a run of normal ones, tracks episode peak/count.
module glycemic_alarm_monitor #(
  parameter int unsigned THRESHOLD     = 4,
  parameter int unsigned TRIGGER_COUNT = 3,
  parameter int unsigned CLEAR_COUNT   = 2
) (
  input logic                      clk,
  input logic                      rst,
  glycemic_alarm_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2,
    RECOVER = 2'd3
  } stateT;

  localparam logic [3:0] THRESH4 = 4'(THRESHOLD);
  localparam logic [2:0] TRIG3   = 3'(TRIGGER_COUNT);
  localparam logic [2:0] CLR3    = 3'(CLEAR_COUNT);

  stateT      stateR, stateS;
  logic [2:0] runR, runS;
  logic [3:0] peakR, peakS;
  logic [7:0] episodeR, episodeS;
  logic       warningR, alarmR;
  logic       enterAlarmS;
  logic       abnormalS;
  logic       ackActiveS;
  logic [2:0] runIncS;

  assign abnormalS  = (bus.glycemicIndex >= THRESH4);
  assign ackActiveS = bus.ackAlarm && ((stateR == ALARM) || (stateR == RECOVER));
  assign runIncS    = runR + 3'd1;

  // Next-state, run counter, peak and episode count
  always_comb begin
    stateS      = stateR;
    runS        = runR;
    peakS       = peakR;
    episodeS    = episodeR;
    enterAlarmS = 1'b0;
    if (ackActiveS) begin
      // acknowledge wins; any sample on this edge is dropped
      stateS = NORMAL;
      runS   = 3'd0;
      peakS  = 4'd0;
    end else if (bus.sampleValid) begin
      case (stateR)
        NORMAL: begin
          if (abnormalS) begin
            if (TRIG3 == 3'd1) begin
              stateS      = ALARM;
              runS        = 3'd0;
              enterAlarmS = 1'b1;
            end else begin
              stateS = SUSPECT;
              runS   = 3'd1;
            end
          end else begin
            stateS = NORMAL;
          end
        end
        SUSPECT: begin
          if (abnormalS) begin
            if (runIncS == TRIG3) begin
              stateS      = ALARM;
              runS        = 3'd0;
              enterAlarmS = 1'b1;
            end else begin
              runS = runIncS;
            end
          end else begin
            stateS = NORMAL;
            runS   = 3'd0;
          end
        end
        ALARM: begin
          if (abnormalS) begin
            stateS = ALARM;
          end else if (CLR3 == 3'd1) begin
            stateS = NORMAL;
            runS   = 3'd0;
          end else begin
            stateS = RECOVER;
            runS   = 3'd1;
          end
        end
        RECOVER: begin
          if (abnormalS) begin
            stateS = ALARM;
            runS   = 3'd0;
          end else if (runIncS == CLR3) begin
            stateS = NORMAL;
            runS   = 3'd0;
          end else begin
            runS = runIncS;
          end
        end
        default: begin
          stateS = NORMAL;
          runS   = 3'd0;
        end
      endcase
      // a new episode starts clean: the sample that ends one is not kept
      if ((stateS == NORMAL) && (stateR != NORMAL)) begin
        peakS = 4'd0;
      end else if (bus.glycemicIndex > peakR) begin
        peakS = bus.glycemicIndex;
      end else begin
        peakS = peakR;
      end
      if (enterAlarmS && (episodeR != 8'd255)) begin
        episodeS = episodeR + 8'd1;
      end else begin
        episodeS = episodeR;
      end
    end else begin
      stateS = stateR;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR   <= NORMAL;
      runR     <= 3'd0;
      peakR    <= 4'd0;
      episodeR <= 8'd0;
      warningR <= 1'b0;
      alarmR   <= 1'b0;
    end else begin
      stateR   <= stateS;
      runR     <= runS;
      peakR    <= peakS;
      episodeR <= episodeS;
      warningR <= (stateS == SUSPECT);
      alarmR   <= (stateS == ALARM) || (stateS == RECOVER);
    end
  end

  assign bus.warning      = warningR;
  assign bus.alarm        = alarmR;
  assign bus.peakIndex    = peakR;
  assign bus.episodeCount = episodeR;

endmodule

// File: tb/tb_glycemic_alarm_monitor.sv
// Directed self-checking bench for glycemic_alarm_monitor with default parameters.
module tb_glycemic_alarm_monitor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  glycemic_alarm_monitor_if bus();

  glycemic_alarm_monitor #(
    .THRESHOLD    (4),
    .TRIGGER_COUNT(3),
    .CLEAR_COUNT  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // one clock of stimulus; returns 1 time unit after the accepting edge
  task automatic drive(input logic v, input logic [3:0] g, input logic a);
    bus.sampleValid   = v;
    bus.glycemicIndex = g;
    bus.ackAlarm      = a;
    @(posedge clk);
    #1;
    bus.sampleValid = 1'b0;
    bus.ackAlarm    = 1'b0;
  endtask

  task automatic resetDut();
    bus.sampleValid   = 1'b0;
    bus.glycemicIndex = 4'd0;
    bus.ackAlarm      = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    resetDut();
    rst = 1'b1;
    #1;
    checks++; if (bus.warning !== 1'b0) begin $display("FAIL reset_warning got %b want 0", bus.warning); errors++; end
    checks++; if (bus.alarm !== 1'b0) begin $display("FAIL reset_alarm got %b want 0", bus.alarm); errors++; end
    checks++; if (bus.peakIndex !== 4'd0) begin $display("FAIL reset_peak got %0d want 0", bus.peakIndex); errors++; end
    checks++; if (bus.episodeCount !== 8'd0) begin $display("FAIL reset_episode got %0d want 0", bus.episodeCount); errors++; end
    rst = 1'b0;
  endtask

  task automatic test_trigger();
    resetDut();
    drive(1'b1, 4'd5, 1'b0);
    checks++; if (bus.warning !== 1'b1) begin $display("FAIL trig_s1_warning got %b want 1", bus.warning); errors++; end
    drive(1'b1, 4'd5, 1'b0);
    checks++; if ({bus.warning, bus.alarm} !== 2'b10) begin $display("FAIL trig_s2_warn_alarm got %b want 10", {bus.warning, bus.alarm}); errors++; end
    drive(1'b1, 4'd5, 1'b0);
    checks++; if ({bus.warning, bus.alarm} !== 2'b01) begin $display("FAIL trig_s3_warn_alarm got %b want 01", {bus.warning, bus.alarm}); errors++; end
    checks++; if (bus.episodeCount !== 8'd1) begin $display("FAIL trig_episode got %0d want 1", bus.episodeCount); errors++; end
    checks++; if (bus.peakIndex !== 4'd5) begin $display("FAIL trig_peak got %0d want 5", bus.peakIndex); errors++; end
  endtask

  task automatic test_abandon();
    resetDut();
    drive(1'b1, 4'd3, 1'b0);
    checks++; if (bus.warning !== 1'b0) begin $display("FAIL thr_below_warning got %b want 0", bus.warning); errors++; end
    checks++; if (bus.peakIndex !== 4'd3) begin $display("FAIL normal_peak got %0d want 3", bus.peakIndex); errors++; end
    drive(1'b1, 4'd4, 1'b0);
    checks++; if (bus.warning !== 1'b1) begin $display("FAIL thr_at_warning got %b want 1", bus.warning); errors++; end
    resetDut();
    drive(1'b1, 4'd6, 1'b0);
    drive(1'b1, 4'd6, 1'b0);
    drive(1'b1, 4'd2, 1'b0);
    checks++; if ({bus.warning, bus.alarm, bus.peakIndex} !== 6'b00_0000) begin $display("FAIL abandon_after2 got %b want 000000", {bus.warning, bus.alarm, bus.peakIndex}); errors++; end
    drive(1'b1, 4'd6, 1'b0);
    checks++; if ({bus.warning, bus.alarm} !== 2'b10) begin $display("FAIL abandon_end_warn_alarm got %b want 10", {bus.warning, bus.alarm}); errors++; end
    checks++; if (bus.peakIndex !== 4'd6) begin $display("FAIL abandon_peak got %0d want 6", bus.peakIndex); errors++; end
    checks++; if (bus.episodeCount !== 8'd0) begin $display("FAIL abandon_episode got %0d want 0", bus.episodeCount); errors++; end
  endtask

  task automatic test_recover();
    resetDut();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd5, 1'b0);
    drive(1'b1, 4'd1, 1'b0);
    checks++; if ({bus.warning, bus.alarm, bus.peakIndex} !== 6'b01_0101) begin $display("FAIL rec_first got %b want 010101", {bus.warning, bus.alarm, bus.peakIndex}); errors++; end
    drive(1'b1, 4'd7, 1'b0);
    checks++; if ({bus.alarm, bus.peakIndex, bus.episodeCount} !== {1'b1, 4'd7, 8'd1}) begin $display("FAIL rec_realarm got a=%b p=%0d e=%0d want a=1 p=7 e=1", bus.alarm, bus.peakIndex, bus.episodeCount); errors++; end
    drive(1'b1, 4'd1, 1'b0);
    checks++; if (bus.alarm !== 1'b1) begin $display("FAIL rec_second_alarm got %b want 1", bus.alarm); errors++; end
    drive(1'b1, 4'd1, 1'b0);
    checks++; if ({bus.alarm, bus.peakIndex, bus.episodeCount} !== {1'b0, 4'd0, 8'd1}) begin $display("FAIL rec_cleared got a=%b p=%0d e=%0d want a=0 p=0 e=1", bus.alarm, bus.peakIndex, bus.episodeCount); errors++; end
  endtask

  task automatic test_ack();
    resetDut();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd5, 1'b0);
    drive(1'b1, 4'd8, 1'b1);
    checks++; if ({bus.warning, bus.alarm, bus.peakIndex} !== 6'b00_0000) begin $display("FAIL ack_priority got %b want 000000", {bus.warning, bus.alarm, bus.peakIndex}); errors++; end
    checks++; if (bus.episodeCount !== 8'd1) begin $display("FAIL ack_episode got %0d want 1", bus.episodeCount); errors++; end
    drive(1'b1, 4'd5, 1'b0);
    drive(1'b1, 4'd6, 1'b1);
    checks++; if ({bus.warning, bus.peakIndex} !== 5'b1_0110) begin $display("FAIL ack_ignored_suspect got %b want 10110", {bus.warning, bus.peakIndex}); errors++; end
    drive(1'b1, 4'd5, 1'b0);
    checks++; if ({bus.alarm, bus.episodeCount} !== {1'b1, 8'd2}) begin $display("FAIL ack_ignored_alarm got a=%b e=%0d want a=1 e=2", bus.alarm, bus.episodeCount); errors++; end
  endtask

  task automatic test_hold_and_async_reset();
    resetDut();
    drive(1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'd8, 1'b0);
      checks++; if ({bus.warning, bus.alarm, bus.peakIndex} !== 6'b10_0101) begin $display("FAIL hold_cycle%0d got %b want 100101", i, {bus.warning, bus.alarm, bus.peakIndex}); errors++; end
    end
    drive(1'b1, 4'd5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.warning, bus.peakIndex} !== 5'b0_0000) begin $display("FAIL async_reset got %b want 00000", {bus.warning, bus.peakIndex}); errors++; end
    #1;
    rst = 1'b0;
    drive(1'b1, 4'd9, 1'b0);
    checks++; if ({bus.warning, bus.alarm, bus.peakIndex} !== 6'b10_1001) begin $display("FAIL first_after_reset got %b want 101001", {bus.warning, bus.alarm, bus.peakIndex}); errors++; end
  endtask

  task automatic test_back_to_back();
    int expEp;
    resetDut();
    for (int i = 1; i <= 256; i++) begin
      for (int k = 0; k < 3; k++) drive(1'b1, 4'd15, 1'b0);
      expEp = (i > 255) ? 255 : i;
      checks++; if ({bus.alarm, bus.peakIndex, bus.episodeCount} !== {1'b1, 4'd15, 8'(expEp)}) begin $display("FAIL b2b_ep%0d got a=%b p=%0d e=%0d want a=1 p=15 e=%0d", i, bus.alarm, bus.peakIndex, bus.episodeCount, expEp); errors++; end
      drive(1'b0, 4'd0, 1'b1);
    end
    checks++; if ({bus.alarm, bus.episodeCount} !== {1'b0, 8'd255}) begin $display("FAIL b2b_final got a=%b e=%0d want a=0 e=255", bus.alarm, bus.episodeCount); errors++; end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.sampleValid   = 1'b0;
    bus.glycemicIndex = 4'd0;
    bus.ackAlarm      = 1'b0;
    test_reset();
    test_trigger();
    test_abandon();
    test_recover();
    test_ack();
    test_hold_and_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/glycemic_alarm_monitor.md
GLYCEMIC_ALARM_MONITOR -- requirements
Module: glycemic_alarm_monitor

Interface
REQ-001 The block SHALL have parameter THRESHOLD, default 4: the glycemicIndex value at or above which a sample is abnormal.
REQ-002 The block SHALL have parameter TRIGGER_COUNT, default 3 (legal range 1..7): consecutive abnormal samples needed to raise the alarm.
REQ-003 The block SHALL have parameter CLEAR_COUNT, default 2 (legal range 1..7): consecutive normal samples needed to clear the alarm.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port sampleValid, input, 1: glycemicIndex holds a new reading this cycle.
REQ-007 Port glycemicIndex, input, 4: the ones-count produced by the upstream abnormality detector, unsigned.
REQ-008 Port ackAlarm, input, 1: operator acknowledge.
REQ-009 Port warning, output, 1: the state is SUSPECT.
REQ-010 Port alarm, output, 1: the state is ALARM or RECOVER.
REQ-011 Port peakIndex, output, 4: maximum accepted glycemicIndex in the current episode.
REQ-012 Port episodeCount, output, 8: number of entries into ALARM since reset.

Function
REQ-013 A sample SHALL be accepted only on a rising clk edge with sampleValid=1. Otherwise all state SHALL hold.
REQ-014 An accepted sample SHALL be abnormal if glycemicIndex >= THRESHOLD, as an unsigned 4-bit compare. Values 9..15 SHALL be treated the same way as any other value.
REQ-015 The FSM SHALL have four states: NORMAL, SUSPECT, ALARM, RECOVER. It SHALL use one 3-bit run counter.
REQ-016 NORMAL, abnormal sample: go to SUSPECT with run=1. If TRIGGER_COUNT=1, go directly to ALARM instead. A normal sample SHALL leave the state in NORMAL.
REQ-017 SUSPECT, abnormal sample: run increments. When run+1 equals TRIGGER_COUNT, go to ALARM with run=0. A normal sample SHALL return the FSM to NORMAL with run=0.
REQ-018 ALARM, normal sample: go to RECOVER with run=1. If CLEAR_COUNT=1, go directly to NORMAL instead. An abnormal sample SHALL leave the state in ALARM.
REQ-019 RECOVER, normal sample: run increments. When run+1 equals CLEAR_COUNT, go to NORMAL with run=0. An abnormal sample SHALL return the FSM to ALARM with run=0.
REQ-020 All outputs SHALL be registered. Their effect SHALL be visible the cycle after the accepting edge, giving latency 1.
REQ-021 peakIndex SHALL update to max(peakIndex, glycemicIndex) on every accepted sample in any state.
REQ-022 peakIndex SHALL clear to 0 on any transition into NORMAL. A sample accepted on that same edge SHALL NOT be merged into peakIndex.
REQ-023 episodeCount SHALL increment on every transition into ALARM from SUSPECT or from NORMAL.
REQ-024 episodeCount SHALL saturate at 255.
REQ-025 A re-entry into ALARM from RECOVER SHALL NOT increment episodeCount.
REQ-026 ackAlarm=1 in ALARM or RECOVER SHALL force NORMAL with run=0 and peakIndex=0.
REQ-027 ackAlarm SHALL take priority over a simultaneous sample, which is discarded. ackAlarm in NORMAL or SUSPECT SHALL be ignored.

Reset
REQ-028 While rst=1, the block SHALL immediately hold the following, regardless of clk: state=NORMAL, run=0, warning=0, alarm=0, peakIndex=0, episodeCount=0.
REQ-029 A reset asserted mid-episode SHALL discard all history.
REQ-030 On the first rising edge after rst deasserts, the block SHALL accept a sample normally.

Verification
REQ-031 Defaults; accepted samples 5,5,5 → warning=1 after the 1st and 2nd samples, then alarm=1 and warning=0 after the 3rd; episodeCount=1; peakIndex=5.
REQ-032 Defaults; samples 6,6,2,6 → SUSPECT is abandoned at the 2 and alarm never rises; peakIndex=6; episodeCount=0.
REQ-033 In ALARM; samples 1,7,1,1 → RECOVER, then ALARM (episodeCount unchanged), then RECOVER, then NORMAL; alarm=0 and peakIndex=0 at the end.
REQ-034 In ALARM; ackAlarm=1 together with sampleValid=1 and glycemicIndex=8 → next cycle state=NORMAL, alarm=0, peakIndex=0.
REQ-035 sampleValid=0 for 10 cycles with glycemicIndex=8 → no state change. Then rst pulsed asynchronously between edges mid-SUSPECT → warning=0 immediately, before the next clk edge.
REQ-036 256 back-to-back alarm episodes, each cleared by ackAlarm → episodeCount=255 and holds there.
